// File: rtl/lcd_reader_if.sv
// ---------------------------------------------------------------------------
// lcd_reader_if
// Bundles the custom-instruction handshake and the HD44780 read-side pins
// used by lcd_reader.
//   clk_en, start, dataa, datab  : custom-instruction controls from the CPU
//   result, done                 : custom-instruction result and completion pulse
//   lcd_data_in                  : LCD data pins, input side
//   lcd_rs, lcd_rw, lcd_enable   : LCD bus-cycle controls
//   lcd_own                      : pin-ownership request towards the top-level mux
// Modports: master = CPU/top-level side, slave = lcd_reader side.
// ---------------------------------------------------------------------------
interface lcd_reader_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic [7:0]  lcd_data_in;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_enable;
    logic        lcd_own;

    modport master (
        output clk_en, start, dataa, datab, lcd_data_in,
        input  result, done, lcd_rs, lcd_rw, lcd_enable, lcd_own
    );

    modport slave (
        input  clk_en, start, dataa, datab, lcd_data_in,
        output result, done, lcd_rs, lcd_rw, lcd_enable, lcd_own
    );
endinterface

// File: rtl/lcd_reader.sv
// ---------------------------------------------------------------------------
// lcd_reader
// Multi-cycle custom instruction performing an HD44780 read bus cycle (RW=1).
// RS=0 returns busy flag + address counter, RS=1 returns a DDRAM/CGRAM byte.
// Optional busy polling is compiled in with the macro LCD_READER_POLL_EN.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : lcd_reader_if.slave (custom-instruction handshake + LCD pins)
//
// result layout: [7:0] captured byte, [8] busy-poll timeout, [31:9] zero.
// All outputs are registered; everything except reset freezes while clk_en=0.
// ---------------------------------------------------------------------------
module lcd_reader #(
    parameter int unsigned T_AS      = 3,
    parameter int unsigned T_PW      = 25,
    parameter int unsigned T_H       = 2,
    parameter int unsigned T_REC     = 10,
    parameter int unsigned MAX_POLLS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    lcd_reader_if.slave bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        max2 = (a > b) ? a : b;
    endfunction

    // One shared down-counter covers every timed state.
    localparam int unsigned CNT_MAX = max2(max2(T_AS, T_PW), max2(T_H, T_REC));
    localparam int unsigned CNT_W   = (CNT_MAX < 32'd2) ? 32'd1 : $clog2(CNT_MAX + 32'd1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] LOAD_AS  = CNT_W'(T_AS - 32'd1);
    localparam logic [CNT_W-1:0] LOAD_PW  = CNT_W'(T_PW - 32'd1);
    localparam logic [CNT_W-1:0] LOAD_H   = CNT_W'(T_H - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
`ifdef LCD_READER_POLL_EN
        REC,
`endif
        DONE
    } state_t;

    state_t           state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic             rs_r, rs_nxt;
    logic             rw_r, rw_nxt;
    logic             en_r, en_nxt;
    logic             own_r, own_nxt;
    logic             done_r, done_nxt;
    logic [7:0]       byte_r, byte_nxt;
    logic             tmo_r, tmo_nxt;
    logic             unused_s;

`ifdef LCD_READER_POLL_EN
    localparam int unsigned        ATT_W    = (MAX_POLLS < 32'd2) ? 32'd1 : $clog2(MAX_POLLS + 32'd1);
    localparam logic [CNT_W-1:0]   LOAD_REC = CNT_W'(T_REC - 32'd1);

    logic             poll_r, poll_nxt;
    logic [ATT_W-1:0] att_r, att_nxt;
    logic             retry_s;

    // Another attempt is allowed only while the attempt budget is not spent.
    assign retry_s = poll_r && byte_r[7] &&
                     ((32'(att_r) + 32'd1) < MAX_POLLS);

    assign unused_s = ^{bus.dataa[31:1], bus.datab[31:1]};
`else
    assign unused_s = ^{bus.dataa[31:1], bus.datab};
`endif

    // Next-state and next-output logic of the read FSM.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        rs_nxt    = rs_r;
        rw_nxt    = rw_r;
        en_nxt    = en_r;
        own_nxt   = own_r;
        done_nxt  = 1'b0;
        byte_nxt  = byte_r;
        tmo_nxt   = tmo_r;
`ifdef LCD_READER_POLL_EN
        poll_nxt  = poll_r;
        att_nxt   = att_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    rs_nxt    = bus.dataa[0];
                    rw_nxt    = 1'b1;
                    own_nxt   = 1'b1;
                    tmo_nxt   = 1'b0;
                    cnt_nxt   = LOAD_AS;
                    state_nxt = SETUP;
`ifdef LCD_READER_POLL_EN
                    // Polling only makes sense on the busy-flag register.
                    poll_nxt  = bus.datab[0] & ~bus.dataa[0];
                    att_nxt   = {ATT_W{1'b0}};
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    en_nxt    = 1'b1;
                    cnt_nxt   = LOAD_PW;
                    state_nxt = PULSE;
                end else begin
                    cnt_nxt   = cnt_r - CNT_ONE;
                end
            end
            PULSE: begin
                // Data is captured on the same edge that drops E.
                if (cnt_r == CNT_ZERO) begin
                    en_nxt    = 1'b0;
                    byte_nxt  = bus.lcd_data_in;
                    cnt_nxt   = LOAD_H;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt   = cnt_r - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    rw_nxt = 1'b0;
`ifdef LCD_READER_POLL_EN
                    if (retry_s) begin
                        att_nxt   = att_r + ATT_W'(1'b1);
                        cnt_nxt   = LOAD_REC;
                        state_nxt = REC;
                    end else begin
                        tmo_nxt   = poll_r & byte_r[7];
                        rs_nxt    = 1'b0;
                        own_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
`else
                    rs_nxt    = 1'b0;
                    own_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_nxt = cnt_r - CNT_ONE;
                end
            end
`ifdef LCD_READER_POLL_EN
            REC: begin
                if (cnt_r == CNT_ZERO) begin
                    rw_nxt    = 1'b1;
                    cnt_nxt   = LOAD_AS;
                    state_nxt = SETUP;
                end else begin
                    cnt_nxt   = cnt_r - CNT_ONE;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                rs_nxt    = 1'b0;
                rw_nxt    = 1'b0;
                en_nxt    = 1'b0;
                own_nxt   = 1'b0;
                cnt_nxt   = CNT_ZERO;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides the clock enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            rs_r    <= 1'b0;
            rw_r    <= 1'b0;
            en_r    <= 1'b0;
            own_r   <= 1'b0;
            done_r  <= 1'b0;
            byte_r  <= 8'h00;
            tmo_r   <= 1'b0;
`ifdef LCD_READER_POLL_EN
            poll_r  <= 1'b0;
            att_r   <= {ATT_W{1'b0}};
`endif
        end else if (bus.clk_en) begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            rs_r    <= rs_nxt;
            rw_r    <= rw_nxt;
            en_r    <= en_nxt;
            own_r   <= own_nxt;
            done_r  <= done_nxt;
            byte_r  <= byte_nxt;
            tmo_r   <= tmo_nxt;
`ifdef LCD_READER_POLL_EN
            poll_r  <= poll_nxt;
            att_r   <= att_nxt;
`endif
        end else begin
            state_r <= state_r;
        end
    end

    assign bus.result     = {23'd0, tmo_r, byte_r};
    assign bus.done       = done_r;
    assign bus.lcd_rs     = rs_r;
    assign bus.lcd_rw     = rw_r;
    assign bus.lcd_enable = en_r;
    assign bus.lcd_own    = own_r;

endmodule

// File: tb/tb_lcd_reader.sv
// ---------------------------------------------------------------------------
// tb_lcd_reader
// Directed plus randomized stimulus for lcd_reader. Expected values come from
// a timing model: a read attempt costs T_AS+T_PW+T_H clocks, each extra poll
// attempt costs T_REC more, and the result is the byte of the last attempt.
// ---------------------------------------------------------------------------
module tb_lcd_reader;

    localparam int MAX_TB = 4;
`ifdef LCD_READER_POLL_EN
    localparam bit POLL_BUILD = 1'b1;
`else
    localparam bit POLL_BUILD = 1'b0;
`endif

    logic clk;
    logic reset;
    int   passes;
    int   total;
    logic [7:0] resp [8];

    lcd_reader_if bus ();

    lcd_reader #(.MAX_POLLS(MAX_TB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Number of read attempts the instruction should make.
    function automatic int exp_pulses(input bit poll);
        if (!poll) return 1;
        for (int i = 0; i < 8; i++) begin
            if (resp[i][7] == 1'b0 || (i + 1) >= MAX_TB) return i + 1;
        end
        return 8;
    endfunction

    task automatic run_read(input string tag, input bit a0, input bit b0,
                            input int stall_s, input int stall_len, input bit busy_start);
        bit          pe;
        int          p, done_cyc, done_cnt, e_hi, rises, first_rise, last_rise;
        int          idx, rs_bad, rw_bad, own_bad, own_after;
        logic        prev_e, own0, rw0, own_done, rw_done;
        logic [31:0] res, tmp, exp_res;
        pe = (a0 == 1'b0) && b0 && POLL_BUILD;
        p  = exp_pulses(pe);
        exp_res = {23'd0, (pe && p == MAX_TB && resp[p-1][7]), resp[p-1]};
        done_cyc = -1; done_cnt = 0; e_hi = 0; rises = 0; first_rise = -1; last_rise = -1;
        idx = 0; rs_bad = 0; rw_bad = 0; own_bad = 0; own_after = 0;
        prev_e = 1'b0; own0 = 1'b0; rw0 = 1'b0; own_done = 1'b1; rw_done = 1'b1; res = 32'hx;

        @(negedge clk);
        tmp = $urandom(); tmp[0] = a0; bus.dataa = tmp;
        tmp = $urandom(); tmp[0] = b0; bus.datab = tmp;
        bus.lcd_data_in = resp[0];
        bus.start = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            bus.start  = (busy_start && k == 20) ? 1'b1 : 1'b0;
            bus.clk_en = (k >= stall_s && k < stall_s + stall_len) ? 1'b0 : 1'b1;
            if (k == 0) begin
                own0 = bus.lcd_own;
                rw0  = bus.lcd_rw;
            end
            if (bus.lcd_enable && !prev_e) begin
                rises++;
                last_rise = k;
                if (first_rise < 0) first_rise = k;
            end
            if (bus.lcd_enable) begin
                e_hi++;
                if (bus.lcd_rw !== 1'b1) rw_bad++;
            end
            if (prev_e && !bus.lcd_enable) begin
                if (idx < 7) idx++;
                bus.lcd_data_in = resp[idx];
            end
            prev_e = bus.lcd_enable;
            if (done_cyc < 0 && bus.done !== 1'b1) begin
                if (bus.lcd_own !== 1'b1) own_bad++;
                if (bus.lcd_rs !== a0) rs_bad++;
            end
            if (done_cyc >= 0 && k > done_cyc && bus.lcd_own !== 1'b0) own_after++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    res      = bus.result;
                    own_done = bus.lcd_own;
                    rw_done  = bus.lcd_rw;
                end
            end
            if (done_cyc >= 0 && k >= done_cyc + 4) break;
        end
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;

        check({tag, "/done_cycle"}, done_cyc, 30 + 40 * (p - 1) + stall_len);
        check({tag, "/result"}, res, exp_res);
        check({tag, "/pulses"}, rises, p);
        check({tag, "/e_high"}, e_hi, 25 * p + stall_len);
        check({tag, "/first_rise"}, first_rise, 3);
        check({tag, "/last_rise"}, last_rise, 3 + 40 * (p - 1));
        check({tag, "/rs_bad"}, rs_bad, 0);
        check({tag, "/rw_bad"}, rw_bad, 0);
        check({tag, "/own_bad"}, own_bad, 0);
        check({tag, "/own0"}, {31'd0, own0}, 32'd1);
        check({tag, "/rw0"}, {31'd0, rw0}, 32'd1);
        check({tag, "/own_at_done"}, {31'd0, own_done}, 32'd0);
        check({tag, "/rw_at_done"}, {31'd0, rw_done}, 32'd0);
        check({tag, "/done_count"}, done_cnt, 1);
        check({tag, "/own_after"}, own_after, 0);
    endtask

    initial begin
        int nb;
        passes = 0;
        total  = 0;
        reset  = 1'b1;
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.dataa  = 32'd0;
        bus.datab  = 32'd0;
        bus.lcd_data_in = 8'h00;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst/result", bus.result, 32'd0);
        check("rst/pins", {28'd0, bus.lcd_rs, bus.lcd_rw, bus.lcd_enable, bus.lcd_own}, 32'd0);
        check("rst/done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Busy/address read.
        resp[0] = 8'h25;
        run_read("busy_read", 1'b0, 1'b0, -100, 0, 1'b0);

        // Data read with the poll bit set: polling must be suppressed.
        resp[0] = 8'hA5;
        run_read("data_read", 1'b1, 1'b1, -100, 0, 1'b0);

        // Poll: busy for three reads, then ready.
        for (int i = 0; i < 3; i++) resp[i] = 8'h80 | 8'($urandom_range(0, 127));
        for (int i = 3; i < 8; i++) resp[i] = 8'h10;
        run_read("poll", 1'b0, 1'b1, -100, 0, 1'b0);

        // Poll timeout: always busy.
        for (int i = 0; i < 8; i++) resp[i] = 8'h80;
        run_read("poll_timeout", 1'b0, 1'b1, -100, 0, 1'b0);

        // Clock-enable stall inside PULSE plus a start while busy.
        resp[0] = 8'h3C;
        run_read("stall", 1'b0, 1'b0, 10, 7, 1'b1);

        // Reset in the middle of a read.
        @(negedge clk);
        bus.dataa = 32'd0;
        bus.datab = 32'd0;
        bus.start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 9) reset = 1'b1;
        end
        @(negedge clk);
        check("midrst/pins", {28'd0, bus.lcd_rs, bus.lcd_rw, bus.lcd_enable, bus.lcd_own}, 32'd0);
        check("midrst/result", bus.result, 32'd0);
        reset = 1'b0;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.lcd_enable === 1'b1) nb++;
        end
        check("midrst/no_activity", nb, 0);
        resp[0] = 8'h47;
        run_read("after_rst", 1'b1, 1'b0, -100, 0, 1'b0);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_start/own", {31'd0, bus.lcd_own}, 32'd0);
        check("rst_start/enable", {31'd0, bus.lcd_enable}, 32'd0);

        // Randomized reads.
        for (int t = 0; t < 6; t++) begin
            bit ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            nb = $urandom_range(0, 4);
            for (int i = 0; i < 8; i++) begin
                resp[i] = 8'($urandom_range(0, 255));
                resp[i] = (i < nb) ? (resp[i] | 8'h80) : (resp[i] & 8'h7F);
            end
            run_read($sformatf("rand%0d", t), ra, rb, -100, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
